// File: rtl/usb_fs_in_ep_arb_if.sv
// Purpose: endpoint write-bus bundle between NUM_EPS IN-endpoint producers,
//          the round-robin arbiter and the IN protocol engine.
// Ports:   req/req_data/req_put/req_done (producers -> arbiter), gnt/req_free/drop_err
//          (arbiter -> producers), in_ep_data* (arbiter <-> protocol engine).
interface usb_fs_in_ep_arb_if #(
    parameter int NUM_EPS = 4
);
    logic [NUM_EPS-1:0]   req;
    logic [8*NUM_EPS-1:0] req_data;
    logic [NUM_EPS-1:0]   req_put;
    logic [NUM_EPS-1:0]   req_done;
    logic [NUM_EPS-1:0]   gnt;
    logic [NUM_EPS-1:0]   req_free;
    logic                 drop_err;
    logic [7:0]           in_ep_data;
    logic [NUM_EPS-1:0]   in_ep_data_put;
    logic [NUM_EPS-1:0]   in_ep_data_done;
    logic [NUM_EPS-1:0]   in_ep_data_free;

    // Arbiter side.
    modport slave (
        input  req, req_data, req_put, req_done, in_ep_data_free,
        output gnt, req_free, drop_err, in_ep_data, in_ep_data_put, in_ep_data_done
    );

    // Producer / protocol-engine side.
    modport master (
        output req, req_data, req_put, req_done, in_ep_data_free,
        input  gnt, req_free, drop_err, in_ep_data, in_ep_data_put, in_ep_data_done
    );
endinterface

// File: rtl/usb_fs_in_ep_arb.sv
// Purpose: packet-granular round-robin arbiter sharing the IN engine's 8-bit endpoint write bus.
// Latency: grant registered 1 cycle after req; data/put/done/free pass through combinationally.
// Backpressure: req_free = gnt & in_ep_data_free; stalled cycles still count toward the idle timeout.
// Ports: clk, reset (sync, active-high), bus (usb_fs_in_ep_arb_if.slave).
module usb_fs_in_ep_arb #(
    parameter int NUM_EPS = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    usb_fs_in_ep_arb_if.slave     bus
);
    localparam int IDX_W = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q;
    logic [NUM_EPS-1:0] gnt_q;
    logic [IDX_W-1:0]   g_q;
    logic [IDX_W-1:0]   last_q;
    logic [TO_W-1:0]    cnt_q;
    logic               drop_err_q;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic               gnt_act;
    logic [TO_W-1:0]    cnt_inc;
    logic [TO_W-1:0]    cnt_d;
    logic               rel_now;
    logic               drop_err_d;
    logic [7:0]         data_mux;

    function automatic logic [IDX_W-1:0] wrap_idx(input int k);
        return IDX_W'(k % NUM_EPS);
    endfunction

    // Scan last+NUM_EPS down to last+1 so the nearest requester after last wins;
    // the previous owner itself is the final candidate (back-to-back only when alone).
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        for (int off = NUM_EPS; off >= 1; off--) begin
            if (bus.req[wrap_idx(int'(last_q) + off)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(int'(last_q) + off);
            end
        end
    end

    // Idle timeout: any put/done from the owner clears, otherwise count up (saturating).
    assign gnt_act = bus.req_put[g_q] | bus.req_done[g_q];
    assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign cnt_d   = gnt_act ? '0 : cnt_inc;
    assign rel_now = bus.req_done[g_q] | ~bus.req[g_q] | (cnt_d >= TO_W'(TIMEOUT));

    // Strobes from anyone not holding the grant are swallowed and flagged.
    assign drop_err_d = |((bus.req_put | bus.req_done) & ~gnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            g_q        <= '0;
            last_q     <= IDX_W'(NUM_EPS - 1);
            cnt_q      <= '0;
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_err_d;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= NUM_EPS'(1) << pick_idx;
                        g_q     <= pick_idx;
                        last_q  <= pick_idx;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    cnt_q <= cnt_d;
                    if (rel_now) begin
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // One-hot AND-OR select; yields zero when nobody is granted.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_EPS; i++) begin
            if (gnt_q[i]) data_mux = data_mux | bus.req_data[8*i +: 8];
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.req_free        = gnt_q & bus.in_ep_data_free;
    assign bus.drop_err        = drop_err_q;
    assign bus.in_ep_data      = data_mux;
    assign bus.in_ep_data_put  = bus.req_put & gnt_q;
    assign bus.in_ep_data_done = bus.req_done & gnt_q;
endmodule

// File: tb/tb_usb_fs_in_ep_arb.sv
module tb_usb_fs_in_ep_arb;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] put;
        logic [N-1:0] done;
        logic [N-1:0] free;
        logic [7:0]   data;
        logic         drop;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    usb_fs_in_ep_arb_if #(.NUM_EPS(N)) bus ();

    usb_fs_in_ep_arb #(.NUM_EPS(N), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    obs_t exp_q[$];

    // Reference model state: owner index (-1 = nobody), rotation pointer, idle run.
    int   m_owner = -1;
    int   m_last  = N - 1;
    int   m_cnt   = 0;
    bit   m_drop  = 1'b0;

    // Monitor logs for directed checks.
    int   gnt_log[$];
    int   hi_q[$];
    int   rise_q[$];
    int   byte_log0[$];
    int   put_cnt[N];
    int   drop_cnt = 0;
    int   run_len = 0;
    int   cyc = 0;
    logic [N-1:0] prev_gnt = '0;

    // Driver state.
    logic [N-1:0] req_mask = '0;
    int   sent[N];
    int   stall_ep = -1;
    int   stall_left = 0;
    int   stray_at = -1;
    logic [N-1:0] stray_mask = '0;

    // Expected bus view for the current cycle, then advance per the arbitration rules.
    always @(negedge clk) begin
        logic [N-1:0] g;
        obs_t e;
        bit busy;
        int idle_run;
        g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.gnt  = g;
        e.put  = bus.req_put & g;
        e.done = bus.req_done & g;
        e.free = bus.in_ep_data_free & g;
        e.data = (m_owner >= 0) ? bus.req_data[8*m_owner +: 8] : 8'h00;
        e.drop = m_drop;
        if (mon_en) exp_q.push_back(e);
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_cnt = 0; m_drop = 1'b0;
        end else begin
            m_drop = |((bus.req_put | bus.req_done) & ~g);
            if (m_owner < 0) begin
                for (int s = 1; s <= N; s++) begin
                    if (m_owner < 0 && bus.req[(m_last + s) % N]) begin
                        m_owner = (m_last + s) % N;
                        m_cnt   = 0;
                    end
                end
                if (m_owner >= 0) m_last = m_owner;
            end else begin
                busy     = bus.req_put[m_owner] | bus.req_done[m_owner];
                idle_run = busy ? 0 : m_cnt + 1;
                m_cnt    = idle_run;
                if (bus.req_done[m_owner] || !bus.req[m_owner] || idle_run >= TO) begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            obs_t a;
            obs_t e;
            #2;
            a.gnt  = bus.gnt;
            a.put  = bus.in_ep_data_put;
            a.done = bus.in_ep_data_done;
            a.free = bus.req_free;
            a.data = bus.in_ep_data;
            a.drop = bus.drop_err;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL bus_obs t=%0t got gnt=%h put=%h done=%h free=%h data=%h drop=%b, want gnt=%h put=%h done=%h free=%h data=%h drop=%b",
                             $time, a.gnt, a.put, a.done, a.free, a.data, a.drop,
                             e.gnt, e.put, e.done, e.free, e.data, e.drop);
                end
            end
            cyc++;
            if (a.gnt != 0 && prev_gnt == 0) begin
                for (int k = 0; k < N; k++) if (a.gnt[k]) gnt_log.push_back(k);
                rise_q.push_back(cyc);
            end
            if (a.gnt != 0) run_len++;
            else if (prev_gnt != 0) begin
                hi_q.push_back(run_len);
                run_len = 0;
            end
            for (int k = 0; k < N; k++) begin
                if (a.put[k]) begin
                    put_cnt[k]++;
                    if (k == 0) byte_log0.push_back(int'(a.data));
                end
            end
            if (a.drop) drop_cnt++;
            prev_gnt = a.gnt;
        end
    end

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.req = '0; bus.req_put = '0; bus.req_done = '0;
        bus.req_data = '0; bus.in_ep_data_free = '1;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); hi_q.delete(); rise_q.delete(); byte_log0.delete();
        for (int k = 0; k < N; k++) begin put_cnt[k] = 0; sent[k] = 0; end
        drop_cnt = 0; run_len = 0;
        stall_ep = -1; stall_left = 0; stray_at = -1; stray_mask = '0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        zero_inputs();
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic settle();
        tick();
        zero_inputs();
        repeat (3) tick();
    endtask

    // Well-behaved producers: the granted one sends len bytes (only when free) then done.
    task automatic run_pkts(input int cycles, input int len, input logic [N-1:0] mute);
        logic [N-1:0]   put_v, done_v, free_v;
        logic [8*N-1:0] dat_v;
        for (int i = 0; i < cycles; i++) begin
            tick();
            put_v = '0; done_v = '0; free_v = '1;
            for (int e = 0; e < N; e++) dat_v[8*e +: 8] = 8'($urandom);
            for (int e = 0; e < N; e++) begin
                if (bus.gnt[e] && e == stall_ep && stall_left > 0) begin
                    free_v[e] = 1'b0;
                    stall_left--;
                end
                if (!bus.gnt[e]) sent[e] = 0;
                else if (!mute[e]) begin
                    if (sent[e] < len) begin
                        if (free_v[e]) begin
                            put_v[e] = 1'b1;
                            dat_v[8*e +: 8] = 8'hA1 + 8'(sent[e]) + 8'(16 * e);
                            sent[e]++;
                        end
                    end else begin
                        done_v[e] = 1'b1;
                        sent[e] = 0;
                    end
                end
            end
            if (i == stray_at) put_v = put_v | stray_mask;
            bus.req = req_mask; bus.req_put = put_v; bus.req_done = done_v;
            bus.req_data = dat_v; bus.in_ep_data_free = free_v;
        end
    endtask

    initial begin
        zero_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Basic packet then rotation to the other pending requester.
        do_reset();
        req_mask = 4'b0101;
        run_pkts(14, 3, '0);
        settle();
        check("t1_first_gnt", qget(gnt_log, 0), 0);
        check("t1_second_gnt", qget(gnt_log, 1), 2);
        check("t1_gnt_len", qget(hi_q, 0), 4);
        check("t1_rise_gap", qget(rise_q, 1) - qget(rise_q, 0), 5);
        check("t1_byte0", qget(byte_log0, 0), 'hA1);
        check("t1_byte1", qget(byte_log0, 1), 'hA2);
        check("t1_byte2", qget(byte_log0, 2), 'hA3);

        // Fairness with all four requesting 1-byte packets.
        do_reset();
        req_mask = 4'b1111;
        run_pkts(20, 1, '0);
        settle();
        for (int k = 0; k < 6; k++) check($sformatf("t2_order%0d", k), qget(gnt_log, k), k % N);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_len%0d", k), qget(hi_q, k), 2);
            check($sformatf("t2_gap%0d", k), qget(rise_q, k + 1) - qget(rise_q, k), 3);
        end

        // Stray put from a non-granted requester.
        do_reset();
        req_mask = 4'b0010;
        stray_at = 2;
        stray_mask = 4'b0100;
        run_pkts(7, 4, '0);
        settle();
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_put2", put_cnt[2], 0);
        check("t3_put1", put_cnt[1], 4);

        // Idle timeout on requester 3, then requester 0 gets the bus.
        do_reset();
        req_mask = 4'b1000;
        run_pkts(2, 1, 4'b1000);
        req_mask = 4'b1001;
        run_pkts(14, 1, 4'b1000);
        settle();
        check("t4_first_gnt", qget(gnt_log, 0), 3);
        check("t4_timeout_len", qget(hi_q, 0), TO);
        check("t4_next_gnt", qget(gnt_log, 1), 0);
        check("t4_rise_gap", qget(rise_q, 1) - qget(rise_q, 0), TO + 1);

        // Backpressure: 4 stalled cycles then 3 puts, grant held throughout.
        do_reset();
        req_mask = 4'b0010;
        stall_ep = 1;
        stall_left = 4;
        run_pkts(12, 3, '0);
        settle();
        check("t5_gnt", qget(gnt_log, 0), 1);
        check("t5_gnt_len", qget(hi_q, 0), 8);
        check("t5_rise_gap", qget(rise_q, 1) - qget(rise_q, 0), 9);

        // Reset in the middle of a 5-byte packet.
        do_reset();
        req_mask = 4'b0001;
        run_pkts(3, 5, '0);
        tick();
        reset = 1'b1;
        bus.req_put = '0;
        bus.req_done = '0;
        tick();
        reset = 1'b0;
        bus.req = '0;
        for (int k = 0; k < 3; k++) begin
            bus.req_put = 4'b0001;
            bus.req_data[7:0] = 8'hA3 + 8'(k);
            tick();
        end
        bus.req_put = '0;
        tick();
        check("t6_fwd_before", put_cnt[0], 2);
        sent[0] = 0;
        req_mask = 4'b1111;
        run_pkts(6, 1, '0);
        settle();
        check("t6_drop_cnt", drop_cnt, 3);
        check("t6_restart_gnt", qget(gnt_log, 1), 0);

        // Randomized traffic, including protocol abuse and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int e = 0; e < N; e++) begin
                if ($urandom_range(7) == 0) bus.req[e] = ~bus.req[e];
                bus.req_put[e]         = ($urandom_range(2) == 0);
                bus.req_done[e]        = ($urandom_range(9) == 0);
                bus.in_ep_data_free[e] = ($urandom_range(3) != 0);
                bus.req_data[8*e +: 8] = 8'($urandom);
            end
            reset = ($urandom_range(199) == 0);
        end
        reset = 1'b0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
